// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU data port: req/ready handshake with fixed wait-state
// latency, alignment/range checking and a saturating committed-write counter.
module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [1:0]  memwrite,
   input  logic [63:0] dataadr,
   input  logic [63:0] writedata,
   output logic [63:0] readdata,
   output logic        ready,
   output logic        err,
   output logic        busy,
   output logic [31:0] wcount
);

   localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] LIMIT    = 64'(DEPTH) * 64'd8;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   localparam logic [1:0] MW_READ  = 2'b00;
   localparam logic [1:0] MW_WORD  = 2'b01;
   localparam logic [1:0] MW_RSVD  = 2'b10;
   localparam logic [1:0] MW_DWORD = 2'b11;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [1:0]  lat_mw;
   logic [63:0] lat_adr;
   logic [63:0] lat_wd;

   logic [63:0]      mem [DEPTH];
   logic [IDX_W-1:0] index;
   logic [63:0]      mem_q;
   logic [63:0]      new_word;
   logic [63:0]      result;
   logic             acc_err;
   logic             is_write;
   logic             commit;

   assign index    = lat_adr[IDX_W+2:3];
   assign mem_q    = mem[index];
   assign is_write = (lat_mw == MW_WORD) || (lat_mw == MW_DWORD);
   assign busy     = (state != IDLE);

   // Error and write-data decode work only on the latched fields, so they are stable
   // for the whole access regardless of what the CPU does to its outputs meanwhile.
   always_comb begin
      acc_err  = 1'b0;
      new_word = mem_q;
      result   = mem_q;
      unique case (lat_mw)
         MW_READ:  acc_err = (lat_adr[2:0] != 3'b000);
         MW_WORD:  acc_err = (lat_adr[1:0] != 2'b00);
         MW_DWORD: acc_err = (lat_adr[2:0] != 3'b000);
         MW_RSVD:  acc_err = 1'b1;
         default:  acc_err = 1'b1;
      endcase
      if (lat_adr >= LIMIT)
         acc_err = 1'b1;

      if (lat_mw == MW_WORD) begin
         if (lat_adr[2])
            new_word = {lat_wd[31:0], mem_q[31:0]};
         else
            new_word = {mem_q[63:32], lat_wd[31:0]};
      end else if (lat_mw == MW_DWORD) begin
         new_word = lat_wd;
      end
      result = is_write ? new_word : mem_q;
   end

   // The write lands on the RESP->IDLE edge, the same edge that raises ready.
   assign commit = (state == RESP) && is_write && !acc_err;

   // NOTE: the storage array has no reset; clearing it would turn the RAM into flops.
   always_ff @(posedge clk) begin
      if (commit)
         mem[index] <= new_word;
   end

   // NOTE: all state below uses non-blocking assignments so every register samples
   // pre-edge values, regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         lat_mw   <= MW_READ;
         lat_adr  <= '0;
         lat_wd   <= '0;
         readdata <= '0;
         ready    <= 1'b0;
         err      <= 1'b0;
         wcount   <= '0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  lat_mw  <= memwrite;
                  lat_adr <= dataadr;
                  lat_wd  <= writedata;
                  cnt     <= CNT_INIT;
                  state   <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1)
                  state <= RESP;
            end
            RESP: begin
               state <= IDLE;
               ready <= 1'b1;
               err   <= acc_err;
               if (acc_err)
                  readdata <= '0;
               else
                  readdata <= result;
               if (commit && (wcount != 32'hFFFF_FFFF))
                  wcount <= wcount + 32'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a directed driver pushes expected responses into a queue and
// a negedge monitor pops and compares them whenever ready is seen.
module tb_dmem_responder;

   localparam int DEPTH   = 64;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [1:0]  memwrite;
   logic [63:0] dataadr;
   logic [63:0] writedata;
   logic [63:0] readdata;
   logic        ready;
   logic        err;
   logic        busy;
   logic [31:0] wcount;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] rd;
      logic        err;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   logic [63:0] burst_adr [6];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .readdata  (readdata),
      .ready     (ready),
      .err       (err),
      .busy      (busy),
      .wcount    (wcount)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
      end
   endtask

   // Monitor: every ready pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_ready", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, "_rdata"}, readdata, mon_e.rd);
            check({mon_e.name, "_err"}, 64'(err), 64'(mon_e.err));
         end
      end
   end

   task automatic access(input string name, input logic [1:0] mw, input logic [63:0] adr,
                         input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err);
      int rdy_at;
      int busy_n;
      bit done;
      @(negedge clk);
      req       = 1'b1;
      memwrite  = mw;
      dataadr   = adr;
      writedata = wd;
      @(posedge clk);
      sb_q.push_back('{rd: exp_rd, err: exp_err, name: name});
      rdy_at = 0;
      busy_n = 0;
      done   = 1'b0;
      for (int i = 1; i <= 20 && !done; i++) begin
         @(negedge clk);
         if (i == 1) begin
            // Scramble the bus so a design that fails to latch its fields is caught.
            req       = 1'b0;
            memwrite  = ~mw;
            dataadr   = ~adr;
            writedata = ~wd;
         end
         if (busy === 1'b1)
            busy_n++;
         if (ready === 1'b1) begin
            rdy_at = i;
            done   = 1'b1;
         end
      end
      check({name, "_latency"}, 64'(rdy_at), 64'(LATENCY + 1));
      check({name, "_busy_cycles"}, 64'(busy_n), 64'(LATENCY));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      req       = 1'b0;
      memwrite  = 2'b00;
      dataadr   = '0;
      writedata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(ready), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rdata", readdata, 64'd0);
      check("rst_wcount", 64'(wcount), 64'd0);
      reset = 1'b0;

      // Dword write, high-word write, read back the merged doubleword.
      access("t1_dw96", 2'b11, 64'd96, 64'd0, 64'd0, 1'b0);
      access("t1_w100", 2'b01, 64'd100, 64'd7, 64'h0000_0007_0000_0000, 1'b0);
      access("t1_rd96", 2'b00, 64'd96, 64'd0, 64'h0000_0007_0000_0000, 1'b0);
      check("t1_wcount", 64'(wcount), 64'd2);

      access("t2_dw320", 2'b11, 64'd320, 64'd4950, 64'd4950, 1'b0);
      access("t2_rd320", 2'b00, 64'd320, 64'd0, 64'd4950, 1'b0);
      check("t2_wcount", 64'(wcount), 64'd3);

      // Error accesses: no write, readdata forced to zero, counter frozen.
      access("t3_dw100", 2'b11, 64'd100, 64'hDEAD_BEEF, 64'd0, 1'b1);
      access("t3_rsvd0", 2'b10, 64'd0, 64'hDEAD_BEEF, 64'd0, 1'b1);
      check("t3_wcount", 64'(wcount), 64'd3);
      access("t3_rd96", 2'b00, 64'd96, 64'd0, 64'h0000_0007_0000_0000, 1'b0);

      // Top index and the first out-of-range word.
      access("t4_dw504", 2'b11, 64'd504, 64'h1111_1111_2222_2222, 64'h1111_1111_2222_2222, 1'b0);
      access("t4_w508", 2'b01, 64'd508, 64'd7, 64'h0000_0007_2222_2222, 1'b0);
      access("t4_w512", 2'b01, 64'd512, 64'd9, 64'd0, 1'b1);
      check("t4_wcount", 64'(wcount), 64'd5);
      access("t4_rd504", 2'b00, 64'd504, 64'd0, 64'h0000_0007_2222_2222, 1'b0);

      // Low-half word write ignores writedata[63:32]; misaligned and far-out accesses.
      access("lo_w96", 2'b01, 64'd96, 64'hFFFF_FFFF_AAAA_AAAA, 64'h0000_0007_AAAA_AAAA, 1'b0);
      access("mis_w98", 2'b01, 64'd98, 64'd1, 64'd0, 1'b1);
      access("mis_rd97", 2'b00, 64'd97, 64'd0, 64'd0, 1'b1);
      access("mis_rd4", 2'b00, 64'd4, 64'd0, 64'd0, 1'b1);
      access("oor_rd", 2'b00, 64'h0000_0100_0000_0000, 64'd0, 64'd0, 1'b1);
      access("dw_0", 2'b11, 64'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0);
      check("pre_abort_wcount", 64'(wcount), 64'd6 + 64'd1);

      // Reset during WAIT aborts the write with no ready pulse.
      @(negedge clk);
      req       = 1'b1;
      memwrite  = 2'b11;
      dataadr   = 64'd0;
      writedata = 64'd5;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      check("abort_busy_before", 64'(busy), 64'd1);
      #1 reset = 1'b1;
      #1;
      check("abort_ready", 64'(ready), 64'd0);
      check("abort_err", 64'(err), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_rdata", readdata, 64'd0);
      check("abort_wcount", 64'(wcount), 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      access("t5_rd0", 2'b00, 64'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);

      // req held high for six edges: only edges k and k+3 are accepted.
      burst_adr = '{64'd96, 64'd320, 64'd504, 64'd0, 64'd8, 64'd16};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         req       = 1'b1;
         memwrite  = 2'b00;
         dataadr   = burst_adr[i];
         writedata = '0;
         @(posedge clk);
         if (i == 0)
            sb_q.push_back('{rd: 64'h0000_0007_AAAA_AAAA, err: 1'b0, name: "t6_first"});
         if (i == 3)
            sb_q.push_back('{rd: 64'h0123_4567_89AB_CDEF, err: 1'b0, name: "t6_second"});
      end
      @(negedge clk);
      req = 1'b0;
      repeat (4) @(negedge clk);
      check("t6_wcount", 64'(wcount), 64'd0);
      check("sb_drain", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
